// File: rtl/kernel_pkg.sv
// Shared definitions for the 3x3 kernel sequencer: mux select codes, tap
// ordering, FSM states and default datapath widths.
package kernel_pkg;

    localparam int DW_DEF = 4;
    localparam int CW_DEF = 4;
    localparam int AW_DEF = 10;

    localparam int         N_TAPS   = 9;
    localparam logic [3:0] LAST_IDX = 4'd8;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_TL   = 4'b0001;
    localparam logic [3:0] SEL_TR   = 4'b0010;
    localparam logic [3:0] SEL_BL   = 4'b0011;
    localparam logic [3:0] SEL_BR   = 4'b0100;
    localparam logic [3:0] SEL_R    = 4'b0101;
    localparam logic [3:0] SEL_L    = 4'b0110;
    localparam logic [3:0] SEL_T    = 4'b0111;
    localparam logic [3:0] SEL_B    = 4'b1000;
    localparam logic [3:0] SEL_C    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Tap index order matches the coefficient address map.
    function automatic logic [3:0] idx_to_sel(input logic [3:0] idx);
        case (idx)
            4'd0:    return SEL_TL;
            4'd1:    return SEL_TR;
            4'd2:    return SEL_BL;
            4'd3:    return SEL_BR;
            4'd4:    return SEL_R;
            4'd5:    return SEL_L;
            4'd6:    return SEL_T;
            4'd7:    return SEL_B;
            4'd8:    return SEL_C;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/kernel_coef_bank.sv
// Nine signed coefficients with a guarded write port and combinational read.
// A write landing on the same edge a window starts is shadowed for that window.
module kernel_coef_bank
    import kernel_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [CW-1:0]        wr_data,
    input  logic                 snap,
    input  logic                 win_end,
    input  logic [3:0]           rd_idx,
    output logic signed [CW-1:0] rd_coef
);

    logic signed [CW-1:0] coef_q [N_TAPS];
    logic signed [CW-1:0] coef_d [N_TAPS];
    logic                 ovr_valid_q, ovr_valid_d;
    logic [3:0]           ovr_idx_q, ovr_idx_d;
    logic signed [CW-1:0] ovr_coef_q, ovr_coef_d;
    logic                 wr_ok;

    assign wr_ok = wr_en && (wr_addr <= LAST_IDX);

    always_comb begin
        coef_d      = coef_q;
        ovr_valid_d = ovr_valid_q;
        ovr_idx_d   = ovr_idx_q;
        ovr_coef_d  = ovr_coef_q;
        if (wr_ok) begin
            coef_d[wr_addr] = wr_data;
        end
        if (win_end) begin
            ovr_valid_d = 1'b0;
        end
        // Keep the pre-write value so the window starting now still sees it.
        if (snap && wr_ok) begin
            ovr_valid_d = 1'b1;
            ovr_idx_d   = wr_addr;
            ovr_coef_d  = coef_q[wr_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            ovr_valid_q <= 1'b0;
            ovr_idx_q   <= '0;
            ovr_coef_q  <= '0;
        end else begin
            coef_q      <= coef_d;
            ovr_valid_q <= ovr_valid_d;
            ovr_idx_q   <= ovr_idx_d;
            ovr_coef_q  <= ovr_coef_d;
        end
    end

    always_comb begin
        rd_coef = '0;
        if (rd_idx <= LAST_IDX) begin
            if (ovr_valid_q && (rd_idx == ovr_idx_q)) begin
                rd_coef = ovr_coef_q;
            end else begin
                rd_coef = coef_q[rd_idx];
            end
        end
    end

endmodule

// File: rtl/kernel_seq_ctrl.sv
// Walks the 3x3 neighbourhood mux through nine taps, multiply-accumulates each
// sample with its coefficient and offers one result per window on valid/ready.
module kernel_seq_ctrl
    import kernel_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic [3:0]    sel,
    input  logic [DW-1:0] k_d,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data
);

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           sel_q, sel_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        out_data_q, out_data_d;

    logic                 start_acc;
    logic                 handshake;
    logic signed [CW-1:0] coef;
    logic signed [CW+DW:0] k_ext, c_ext, prod;
    logic [AW-1:0]        prod_ext;
    logic [AW-1:0]        acc_sum;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign handshake = (state_q == ST_DONE) && out_ready;

    kernel_coef_bank #(
        .CW (CW)
    ) u_coef_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_we && (state_q == ST_IDLE)),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .snap    (start_acc),
        .win_end (handshake),
        .rd_idx  (idx_q),
        .rd_coef (coef)
    );

    // Sample is unsigned, so it gets a zero top bit before the signed multiply.
    assign k_ext    = signed'({{(CW + 1){1'b0}}, k_d});
    assign c_ext    = {{(DW + 1){coef[CW-1]}}, coef};
    assign prod     = k_ext * c_ext;
    assign prod_ext = {{(AW - CW - DW - 1){prod[CW+DW]}}, prod};
    assign acc_sum  = acc_q + prod_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sel_q      <= SEL_NONE;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        sel_d      = SEL_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    acc_d   = '0;
                    sel_d   = idx_to_sel(4'd0);
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_DONE;
                    out_data_d = acc_sum;
                end else begin
                    idx_d = idx_q + 4'd1;
                    sel_d = idx_to_sel(idx_q + 4'd1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        acc_d   = '0;
                        sel_d   = idx_to_sel(4'd0);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
        sel       = sel_q;
        out_data  = out_data_q;
    end

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// Directed bench for kernel_seq_ctrl: a behavioural mux feeds samples by select
// code and a queue of expected window sums is checked at each handshake.
module tb_kernel_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic [3:0] sel;
    logic [3:0] k_d;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;

    int pix [9];
    int tb_coef [9];
    int sel_trace [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 15};
    int exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    bit aborted;

    kernel_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .sel       (sel),
        .k_d       (k_d),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural neighbourhood mux: code 0 returns 0, C is code 15.
    always_comb begin
        k_d = 4'd0;
        if (sel >= 4'd1 && sel <= 4'd8) begin
            k_d = 4'(pix[int'(sel) - 1]);
        end else if (sel == 4'd15) begin
            k_d = 4'(pix[8]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int expSum();
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            s += pix[i] * tb_coef[i];
        end
        return s;
    endfunction

    task automatic writeCoef(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = 4'(v);
        tick();
        cfg_we = 1'b0;
        if (a <= 8) tb_coef[a] = v;
    endtask

    task automatic applyStimulus(input bit with_cfg, input int a, input int v);
        start = 1'b1;
        exp_q.push_back(expSum());
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(a);
            cfg_data = 4'(v);
        end
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        if (with_cfg && a <= 8) tb_coef[a] = v;
        checkOutput("busy_after_start", busy, 1);
    endtask

    // poke_kind: 0 none, 1 start in RUN, 2 cfg write addr 8, 3 reset.
    task automatic trackWindow(input int poke_kind, input int poke_i, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("sel_idx%0d", i), sel, sel_trace[i]);
            if (i == poke_i) begin
                case (poke_kind)
                    1: start = 1'b1;
                    2: begin
                        cfg_we   = 1'b1;
                        cfg_addr = 4'd8;
                        cfg_data = 4'd3;
                    end
                    3: rst_n = 1'b0;
                    default: ;
                endcase
            end
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
            if (poke_kind == 3 && i == poke_i) begin
                rst_n = 1'b1;
                checkOutput("rst_sel", sel, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_valid", out_valid, 0);
                checkOutput("rst_data", $signed(out_data), 0);
                for (int k = 0; k < 9; k++) tb_coef[k] = 0;
                void'(exp_q.pop_front());
                ab = 1'b1;
                return;
            end
        end
        checkOutput("valid_at_10", out_valid, 1);
        checkOutput("sel_done_none", sel, 0);
    endtask

    task automatic finishWindow(input int hold, input bit b2b);
        int waited = 0;
        int expv;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("valid_timeout", out_valid, 1);
        checkOutput("scoreboard_depth", exp_q.size(), 1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        for (int h = 0; h < hold; h++) begin
            checkOutput("bp_data", $signed(out_data), expv);
            checkOutput("bp_busy", busy, 1);
            checkOutput("bp_valid", out_valid, 1);
            tick();
        end
        checkOutput("out_data", $signed(out_data), expv);
        out_ready = 1'b1;
        start     = b2b;
        if (b2b) exp_q.push_back(expSum());
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("busy_after_hs", busy, b2b);
        checkOutput("valid_after_hs", out_valid, 0);
        if (b2b) checkOutput("b2b_sel", sel, 1);
        else     checkOutput("idle_sel", sel, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_data  = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix[i]     = 0;
            tb_coef[i] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data", $signed(out_data), 0);

        $display("[TB] identity kernel");
        for (int i = 0; i < 9; i++) pix[i] = 3;
        pix[8] = 5;
        writeCoef(8, 1);
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);

        $display("[TB] box and extreme kernels");
        for (int i = 0; i < 9; i++) begin
            pix[i] = 7;
            writeCoef(i, 1);
        end
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);
        for (int i = 0; i < 9; i++) writeCoef(i, -8);
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(5, 1'b1);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);

        $display("[TB] ignored requests");
        for (int i = 0; i < 9; i++) begin
            pix[i] = i + 1;
            writeCoef(i, i - 4);
        end
        applyStimulus(1'b0, 0, 0);
        trackWindow(1, 3, aborted);
        finishWindow(0, 1'b0);
        applyStimulus(1'b0, 0, 0);
        trackWindow(2, 5, aborted);
        finishWindow(0, 1'b0);
        writeCoef(9, 7);
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);

        $display("[TB] cfg write together with start");
        applyStimulus(1'b1, 8, -1);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);

        $display("[TB] reset mid-window");
        applyStimulus(1'b0, 0, 0);
        trackWindow(3, 4, aborted);
        checkOutput("aborted_flag", aborted, 1);
        applyStimulus(1'b0, 0, 0);
        trackWindow(0, -1, aborted);
        finishWindow(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
